// File: rtl/biu_arb_pkg.sv
// Shared types and helpers for the BIU read/write arbiter.
package biu_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } arb_state_e;

    // Bits needed to hold a count from 0 up to and including `cycles`.
    function automatic int unsigned wdog_width(input int unsigned cycles);
        return $clog2(cycles + 1);
    endfunction

endpackage

// File: rtl/biu_arb_wdog.sv
// Busy-cycle watchdog: cleared on load, counts while enabled, flags the last allowed cycle.
module biu_arb_wdog #(
    parameter int unsigned LIMIT = 256,
    parameter int unsigned CNT_W = 9
) (
    input  logic S_AXI_ACLK,
    input  logic S_AXI_ARESETn,
    input  logic load,
    input  logic count,
    output logic expired_c
);

    logic [CNT_W-1:0] cnt;

    // Saturates at LIMIT so a stuck count never wraps back into range.
    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETn) begin
        if (!S_AXI_ARESETn) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= '0;
        end else if (count && (cnt != CNT_W'(LIMIT))) begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    assign expired_c = count && (cnt == CNT_W'(LIMIT - 1));

endmodule

// File: rtl/biu_rw_arbiter.sv
// Round-robin arbiter sharing one register bus between the BIU write and read paths.
// Optional busy watchdog enabled by defining BIU_RW_ARBITER_TIMEOUT_EN.
module biu_rw_arbiter
    import biu_arb_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH     = 32,
    parameter int unsigned DATA_WIDTH     = 32,
    parameter int unsigned TIMEOUT_CYCLES = 256
) (
    input  logic                    S_AXI_ACLK,
    input  logic                    S_AXI_ARESETn,
    input  logic [ADDR_WIDTH-1:0]   biu_waddr,
    input  logic                    biu_wenable,
    input  logic [DATA_WIDTH-1:0]   biu_wdata,
    input  logic [DATA_WIDTH/8-1:0] biu_wben,
    output logic                    biu_waccept,
    output logic                    biu_werror,
    input  logic [ADDR_WIDTH-1:0]   biu_raddr,
    input  logic                    biu_renable,
    output logic [DATA_WIDTH-1:0]   biu_rdata,
    output logic                    biu_raccept,
    output logic                    biu_rerror,
    output logic                    reg_req,
    output logic                    reg_we,
    output logic [ADDR_WIDTH-1:0]   reg_addr,
    output logic [DATA_WIDTH-1:0]   reg_wdata,
    output logic [DATA_WIDTH/8-1:0] reg_wben,
    input  logic                    reg_ack,
    input  logic [DATA_WIDTH-1:0]   reg_rdata,
    input  logic                    reg_err
);

    arb_state_e state;
    logic       last_wr;
    logic       grant_c;
    logic       wr_win_c;
    logic       tie_c;
    logic       wdog_expired_c;

    assign grant_c  = (state == ST_IDLE) && (biu_wenable || biu_renable);
    assign tie_c    = biu_wenable && biu_renable;
    // On a tie the path that did not win the previous tie goes first.
    assign wr_win_c = biu_wenable && !(biu_renable && last_wr);

`ifdef BIU_RW_ARBITER_TIMEOUT_EN
    localparam int unsigned WDOG_W = wdog_width(TIMEOUT_CYCLES);

    biu_arb_wdog #(
        .LIMIT (TIMEOUT_CYCLES),
        .CNT_W (WDOG_W)
    ) u_wdog (
        .S_AXI_ACLK    (S_AXI_ACLK),
        .S_AXI_ARESETn (S_AXI_ARESETn),
        .load          (grant_c),
        .count         (state == ST_BUSY),
        .expired_c     (wdog_expired_c)
    );
`else
    assign wdog_expired_c = 1'b0;
`endif

    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETn) begin
        if (!S_AXI_ARESETn) begin
            state       <= ST_IDLE;
            last_wr     <= 1'b0;
            reg_req     <= 1'b0;
            reg_we      <= 1'b0;
            reg_addr    <= '0;
            reg_wdata   <= '0;
            reg_wben    <= '0;
            biu_waccept <= 1'b0;
            biu_werror  <= 1'b0;
            biu_raccept <= 1'b0;
            biu_rerror  <= 1'b0;
            biu_rdata   <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (grant_c) begin
                        reg_req <= 1'b1;
                        reg_we  <= wr_win_c;
                        if (tie_c) begin
                            last_wr <= wr_win_c;
                        end
                        if (wr_win_c) begin
                            reg_addr  <= biu_waddr;
                            reg_wdata <= biu_wdata;
                            reg_wben  <= biu_wben;
                        end else begin
                            reg_addr  <= biu_raddr;
                            reg_wdata <= '0;
                            reg_wben  <= '0;
                        end
                        state <= ST_BUSY;
                    end
                end
                ST_BUSY: begin
                    // A real ack always beats a watchdog expiry in the same cycle.
                    if (reg_ack) begin
                        reg_req     <= 1'b0;
                        biu_waccept <= reg_we;
                        biu_raccept <= !reg_we;
                        biu_werror  <= reg_we && reg_err;
                        biu_rerror  <= !reg_we && reg_err;
                        biu_rdata   <= reg_we ? '0 : reg_rdata;
                        state       <= ST_DONE;
                    end else if (wdog_expired_c) begin
                        reg_req     <= 1'b0;
                        biu_waccept <= reg_we;
                        biu_raccept <= !reg_we;
                        biu_werror  <= reg_we;
                        biu_rerror  <= !reg_we;
                        biu_rdata   <= '0;
                        state       <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    biu_waccept <= 1'b0;
                    biu_raccept <= 1'b0;
                    biu_werror  <= 1'b0;
                    biu_rerror  <= 1'b0;
                    state       <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_biu_rw_arbiter.sv
// Directed self-checking bench for biu_rw_arbiter; the timeout case runs when BIU_RW_ARBITER_TIMEOUT_EN is defined.
module tb_biu_rw_arbiter;

    localparam int unsigned AW = 32;
    localparam int unsigned DW = 32;

    logic          S_AXI_ACLK;
    logic          S_AXI_ARESETn;
    logic [AW-1:0] biu_waddr;
    logic          biu_wenable;
    logic [DW-1:0] biu_wdata;
    logic [3:0]    biu_wben;
    logic          biu_waccept;
    logic          biu_werror;
    logic [AW-1:0] biu_raddr;
    logic          biu_renable;
    logic [DW-1:0] biu_rdata;
    logic          biu_raccept;
    logic          biu_rerror;
    logic          reg_req;
    logic          reg_we;
    logic [AW-1:0] reg_addr;
    logic [DW-1:0] reg_wdata;
    logic [3:0]    reg_wben;
    logic          reg_ack;
    logic [DW-1:0] reg_rdata;
    logic          reg_err;

    int n_chk = 0;
    int n_err = 0;

    biu_rw_arbiter #(
        .ADDR_WIDTH     (AW),
        .DATA_WIDTH     (DW),
        .TIMEOUT_CYCLES (8)
    ) dut (
        .S_AXI_ACLK    (S_AXI_ACLK),
        .S_AXI_ARESETn (S_AXI_ARESETn),
        .biu_waddr     (biu_waddr),
        .biu_wenable   (biu_wenable),
        .biu_wdata     (biu_wdata),
        .biu_wben      (biu_wben),
        .biu_waccept   (biu_waccept),
        .biu_werror    (biu_werror),
        .biu_raddr     (biu_raddr),
        .biu_renable   (biu_renable),
        .biu_rdata     (biu_rdata),
        .biu_raccept   (biu_raccept),
        .biu_rerror    (biu_rerror),
        .reg_req       (reg_req),
        .reg_we        (reg_we),
        .reg_addr      (reg_addr),
        .reg_wdata     (reg_wdata),
        .reg_wben      (reg_wben),
        .reg_ack       (reg_ack),
        .reg_rdata     (reg_rdata),
        .reg_err       (reg_err)
    );

    initial S_AXI_ACLK = 1'b0;
    always #5 S_AXI_ACLK = ~S_AXI_ACLK;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
        end
    endtask

    // Inputs change and outputs are sampled at the falling edge.
    task automatic tick();
        @(negedge S_AXI_ACLK);
    endtask

    task automatic do_reset();
        S_AXI_ARESETn = 1'b0;
        tick();
        tick();
        S_AXI_ARESETn = 1'b1;
        tick();
    endtask

    // Ack the outstanding access now; outputs are then checked one edge later.
    task automatic ack_now(input logic [31:0] data, input logic err);
        reg_ack   = 1'b1;
        reg_rdata = data;
        reg_err   = err;
        tick();
        reg_ack   = 1'b0;
        reg_rdata = '0;
        reg_err   = 1'b0;
    endtask

    initial begin
        S_AXI_ARESETn = 1'b0;
        biu_waddr = '0; biu_wenable = 1'b0; biu_wdata = '0; biu_wben = '0;
        biu_raddr = '0; biu_renable = 1'b0;
        reg_ack = 1'b0; reg_rdata = '0; reg_err = 1'b0;
        do_reset();

        check("rst_req", 32'(reg_req), 32'd0);
        check("rst_acc", {30'd0, biu_waccept, biu_raccept}, 32'd0);
        check("rst_rdata", biu_rdata, 32'd0);

        // Single write, ack two cycles after reg_req
        biu_waddr = 32'h10; biu_wdata = 32'hA5A5A5A5; biu_wben = 4'hF; biu_wenable = 1'b1;
        tick();
        check("w1_req", 32'(reg_req), 32'd1);
        check("w1_we", 32'(reg_we), 32'd1);
        check("w1_addr", reg_addr, 32'h10);
        check("w1_wdata", reg_wdata, 32'hA5A5A5A5);
        check("w1_wben", 32'(reg_wben), 32'hF);
        tick();
        check("w1_acc_early", 32'(biu_waccept), 32'd0);
        tick();
        ack_now(32'hDEADBEEF, 1'b0);
        check("w1_waccept", 32'(biu_waccept), 32'd1);
        check("w1_werror", 32'(biu_werror), 32'd0);
        check("w1_raccept", 32'(biu_raccept), 32'd0);
        check("w1_req_drop", 32'(reg_req), 32'd0);
        biu_wenable = 1'b0;
        tick();
        check("w1_pulse_end", 32'(biu_waccept), 32'd0);

        // Single read returning data with an error
        biu_raddr = 32'h20; biu_renable = 1'b1;
        tick();
        check("r1_we", 32'(reg_we), 32'd0);
        check("r1_addr", reg_addr, 32'h20);
        ack_now(32'h12345678, 1'b1);
        check("r1_raccept", 32'(biu_raccept), 32'd1);
        check("r1_rdata", biu_rdata, 32'h12345678);
        check("r1_rerror", 32'(biu_rerror), 32'd1);
        check("r1_werror", 32'(biu_werror), 32'd0);
        biu_renable = 1'b0;
        tick();
        check("r1_pulse_end", 32'(biu_raccept), 32'd0);
        check("r1_rdata_hold", biu_rdata, 32'h12345678);

        // Tie after reset: write first, then read; a second tie favours read
        do_reset();
        biu_waddr = 32'h100; biu_wdata = 32'h11111111; biu_wben = 4'h3; biu_wenable = 1'b1;
        biu_raddr = 32'h200; biu_renable = 1'b1;
        tick();
        check("t1_first_we", 32'(reg_we), 32'd1);
        check("t1_first_addr", reg_addr, 32'h100);
        ack_now(32'h0, 1'b0);
        check("t1_waccept", {30'd0, biu_waccept, biu_raccept}, 32'd2);
        biu_wenable = 1'b0;
        tick();
        check("t1_no_grant_done", 32'(reg_req), 32'd0);
        tick();
        check("t1_second_req", 32'(reg_req), 32'd1);
        check("t1_second_we", 32'(reg_we), 32'd0);
        check("t1_second_addr", reg_addr, 32'h200);
        ack_now(32'hCAFE0001, 1'b0);
        check("t1_raccept", {30'd0, biu_waccept, biu_raccept}, 32'd1);
        biu_renable = 1'b0;
        tick();
        biu_wenable = 1'b1; biu_renable = 1'b1;
        tick();
        check("t2_first_we", 32'(reg_we), 32'd0);
        check("t2_first_addr", reg_addr, 32'h200);
        ack_now(32'hCAFE0002, 1'b0);
        check("t2_raccept", {30'd0, biu_waccept, biu_raccept}, 32'd1);
        biu_renable = 1'b0;
        tick();
        tick();
        check("t2_second_we", 32'(reg_we), 32'd1);
        check("t2_second_wben", 32'(reg_wben), 32'h3);
        ack_now(32'h0, 1'b0);
        check("t2_waccept", {30'd0, biu_waccept, biu_raccept}, 32'd2);
        check("t2_wr_rdata_zero", biu_rdata, 32'd0);
        biu_wenable = 1'b0;
        tick();

        // Back-to-back reads, ack held one cycle: req, ack, accept cycles
        for (int i = 0; i < 3; i++) begin
            biu_raddr = 32'h40 + 32'(i * 4); biu_renable = 1'b1;
            tick();
            check("b2b_req", 32'(reg_req), 32'd1);
            check("b2b_addr", reg_addr, 32'h40 + 32'(i * 4));
            check("b2b_acc_early", 32'(biu_raccept), 32'd0);
            tick();
            check("b2b_acc_on_ack", 32'(biu_raccept), 32'd0);
            ack_now(32'hB0B00000 + 32'(i), 1'b0);
            check("b2b_raccept", 32'(biu_raccept), 32'd1);
            check("b2b_rdata", biu_rdata, 32'hB0B00000 + 32'(i));
            biu_renable = 1'b0;
            tick();
            check("b2b_no_double", 32'(biu_raccept), 32'd0);
        end

        // Reset while an access is outstanding
        biu_waddr = 32'h80; biu_wdata = 32'h5A5A5A5A; biu_wben = 4'hC; biu_wenable = 1'b1;
        tick();
        check("rb_req_before", 32'(reg_req), 32'd1);
        #2 S_AXI_ARESETn = 1'b0;
        #1;
        check("rb_req", 32'(reg_req), 32'd0);
        check("rb_acc", {30'd0, biu_waccept, biu_raccept}, 32'd0);
        check("rb_addr", reg_addr, 32'd0);
        biu_wenable = 1'b0;
        tick();
        S_AXI_ARESETn = 1'b1;
        tick();
        check("rb_idle", 32'(reg_req), 32'd0);
        biu_raddr = 32'h24; biu_renable = 1'b1;
        tick();
        check("rb_new_addr", reg_addr, 32'h24);
        ack_now(32'h0BADF00D, 1'b0);
        check("rb_new_raccept", 32'(biu_raccept), 32'd1);
        check("rb_new_rdata", biu_rdata, 32'h0BADF00D);
        biu_renable = 1'b0;
        tick();

`ifdef BIU_RW_ARBITER_TIMEOUT_EN
        // Read never acked: watchdog ends it after 8 busy cycles
        biu_raddr = 32'h30; biu_renable = 1'b1;
        tick();
        check("to_req_c1", 32'(reg_req), 32'd1);
        for (int c = 2; c <= 8; c++) begin
            tick();
            check("to_req_held", 32'(reg_req), 32'd1);
        end
        tick();
        check("to_req_drop", 32'(reg_req), 32'd0);
        check("to_raccept", 32'(biu_raccept), 32'd1);
        check("to_rerror", 32'(biu_rerror), 32'd1);
        check("to_rdata", biu_rdata, 32'd0);
        biu_renable = 1'b0;
        tick();
        check("to_pulse_end", 32'(biu_raccept), 32'd0);
`endif

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

    // Global guard so the bench always ends.
    initial begin
        #100000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1, "bench timed out");
    end

endmodule
